ad_frame_packer: RTL and testbench

//  Consumer of the AD7606 controller's synchronised sample stream (ad_ch_syn / data_flag_syn).

---
 rtl/ad_pkg.sv | 25 ++
 rtl/ad_frame_packer_if.sv | 11 +
 rtl/ad_sample_fifo.sv | 54 +++++
 rtl/ad_frame_packer.sv | 122 ++++++++++++
 tb/tb_ad_frame_packer.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/ad_pkg.sv
// rtl/ad_pkg.sv - shared tag layout, state encoding and tag builder for the frame packer
package ad_pkg;
  localparam int FRAME_TAG_W  = 8;
  localparam int TAG_LAST_OFF = 0;
  localparam int TAG_CH_OFF   = 1;
  localparam int TAG_SEQ_OFF  = 4;
  localparam int CH_ID_W      = 3;
  localparam int SEQ_W        = 4;

  typedef enum logic {
    S_WAIT  = 1'b0,
    S_FRAME = 1'b1
  } state_t;

  function automatic logic [FRAME_TAG_W-1:0] make_tag(input logic [SEQ_W-1:0] s,
                                                      input logic [CH_ID_W-1:0] c,
                                                      input logic l);
    logic [FRAME_TAG_W-1:0] t;
    t = '0;
    t[TAG_SEQ_OFF +: SEQ_W] = s;
    t[TAG_CH_OFF +: CH_ID_W] = c;
    t[TAG_LAST_OFF] = l;
    return t;
  endfunction
endpackage

// File: rtl/ad_frame_packer_if.sv
// rtl/ad_frame_packer_if.sv - tagged-sample output stream towards the processor
interface ad_frame_packer_if #(parameter int DW = 16);
  import ad_pkg::*;

  logic [DW+FRAME_TAG_W-1:0] out_data;
  logic                      out_valid;
  logic                      out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/ad_sample_fifo.sv
// rtl/ad_sample_fifo.sv - synchronous FIFO with registered first-word-fall-through head
module ad_sample_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic [W-1:0]             head_data,
  output logic                     head_valid
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic         do_push, do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign level   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign wr_nxt  = wr_ptr + (AW+1)'(do_push);
  assign rd_nxt  = rd_ptr + (AW+1)'(do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Head is rebuilt from next-state pointers; a word written into an empty slot bypasses the array.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      head_data  <= '0;
      head_valid <= 1'b0;
    end else begin
      wr_ptr     <= wr_nxt;
      rd_ptr     <= rd_nxt;
      head_valid <= (wr_nxt != rd_nxt);
      if (wr_nxt == rd_nxt)
        head_data <= '0;
      else if (do_push && (wr_ptr[AW-1:0] == rd_nxt[AW-1:0]))
        head_data <= push_data;
      else
        head_data <= mem[rd_nxt[AW-1:0]];
    end
  end
endmodule

// File: rtl/ad_frame_packer.sv
// rtl/ad_frame_packer.sv - tags AD7606 samples with channel id and frame sequence, buffers them
module ad_frame_packer
  import ad_pkg::*;
#(
  parameter int DW     = 16,
  parameter int NCH    = 8,
  parameter int DEPTH  = 32,
  parameter int GAP_TO = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NCH-1:0]         channel,
  input  logic [DW-1:0]          smp_data,
  input  logic                   smp_vld,
  ad_frame_packer_if.master      stream,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   frame_done,
  output logic                   overflow,
  output logic                   frame_err,
  input  logic                   err_clr
);
  localparam int CW = $clog2(NCH);
  localparam int GW = $clog2(GAP_TO + 1);
  localparam int TW = DW + FRAME_TAG_W;

  state_t          state;
  logic [NCH-1:0]  mask_q, base_mask, search;
  logic [CW-1:0]   ch_ptr, hit_idx;
  logic [SEQ_W-1:0] seq;
  logic [GW-1:0]   gap_cnt;
  logic            hit_last, tag_en, timeout;
  logic            push, pop, drop, full, empty, head_valid;
  logic [TW-1:0]   push_data, head_data;

  function automatic logic [NCH-1:0] above(input logic [CW-1:0] p);
    logic [NCH:0] low;
    low = ((NCH+1)'(2) << p) - (NCH+1)'(1);
    return ~low[NCH-1:0];
  endfunction

  function automatic logic [CW-1:0] lowest(input logic [NCH-1:0] v);
    logic [CW-1:0] r;
    r = '0;
    for (int i = NCH-1; i >= 0; i--)
      if (v[i]) r = CW'(i);
    return r;
  endfunction

  // A new frame searches the live mask; within a frame only bits above ch_ptr of the frozen mask.
  always_comb begin
    base_mask = (state == S_WAIT) ? channel : mask_q;
    search    = (state == S_WAIT) ? channel : (mask_q & above(ch_ptr));
    hit_idx   = lowest(search);
    hit_last  = (base_mask & above(hit_idx)) == '0;
    tag_en    = smp_vld && (search != '0);
    timeout   = (state == S_FRAME) && !smp_vld && (gap_cnt == GW'(GAP_TO - 1));
  end

  assign pop  = stream.out_ready && !empty;
  assign drop = push && full && !pop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_WAIT;
      mask_q     <= '0;
      ch_ptr     <= '0;
      seq        <= '0;
      gap_cnt    <= '0;
      push       <= 1'b0;
      push_data  <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      push       <= tag_en;
      frame_done <= 1'b0;
      overflow   <= (overflow && !err_clr) || drop;
      frame_err  <= (frame_err && !err_clr) || timeout;

      if (state == S_WAIT && smp_vld) mask_q <= channel;

      if (state == S_WAIT || smp_vld) begin
        gap_cnt <= '0;
      end else if (timeout) begin
        gap_cnt <= '0;
        state   <= S_WAIT;
        ch_ptr  <= '0;
      end else begin
        gap_cnt <= gap_cnt + 1'b1;
      end

      if (tag_en) begin
        push_data <= {make_tag(seq, CH_ID_W'(hit_idx), hit_last), smp_data};
        if (hit_last) begin
          state      <= S_WAIT;
          ch_ptr     <= '0;
          seq        <= seq + 1'b1;
          frame_done <= 1'b1;
        end else begin
          state  <= S_FRAME;
          ch_ptr <= hit_idx;
        end
      end
    end
  end

  ad_sample_fifo #(.W(TW), .DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_data  (push_data),
    .pop        (pop),
    .full       (full),
    .empty      (empty),
    .level      (fifo_level),
    .head_data  (head_data),
    .head_valid (head_valid)
  );

  assign stream.out_data  = head_data;
  assign stream.out_valid = head_valid;
endmodule

// File: tb/tb_ad_frame_packer.sv
// tb/tb_ad_frame_packer.sv - self-checking bench for ad_frame_packer against a queue-based model
module tb_ad_frame_packer;
  localparam int DW = 16, NCH = 8, DEPTH = 32, GAP_TO = 64;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NCH-1:0] channel = '1;
  logic [DW-1:0]  smp_data = '0;
  logic           smp_vld = 1'b0;
  logic           err_clr = 1'b0;
  logic [5:0]     fifo_level;
  logic           frame_done, overflow, frame_err;

  ad_frame_packer_if #(.DW(DW)) stream();

  ad_frame_packer #(.DW(DW), .NCH(NCH), .DEPTH(DEPTH), .GAP_TO(GAP_TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .channel    (channel),
    .smp_data   (smp_data),
    .smp_vld    (smp_vld),
    .stream     (stream),
    .fifo_level (fifo_level),
    .frame_done (frame_done),
    .overflow   (overflow),
    .frame_err  (frame_err),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: FIFO as a queue, frame as a list of enabled channels walked by index.
  logic [23:0] q[$];
  logic [23:0] pend_w;
  bit          pend_v = 0;
  bit          in_frame = 0;
  int          chl[$];
  int          k = 0;
  int          idle = 0;
  logic [3:0]  m_seq = '0;
  bit          e_done = 0, e_ov = 0, e_ferr = 0;

  always @(posedge clk) begin
    bit pop_m, drop_m, ferr_set, last_m;
    if (!rst_n) begin
      q.delete();
      pend_v = 0; in_frame = 0; k = 0; idle = 0; m_seq = '0;
      e_done = 0; e_ov = 0; e_ferr = 0;
    end else begin
      pop_m  = (q.size() > 0) && stream.out_ready;
      drop_m = pend_v && (q.size() == DEPTH) && !pop_m;
      if (pop_m) void'(q.pop_front());
      if (pend_v && !drop_m) q.push_back(pend_w);
      pend_v = 0; e_done = 0; ferr_set = 0;
      if (smp_vld) begin
        if (!in_frame && channel != '0) begin
          chl.delete();
          for (int i = 0; i < NCH; i++) if (channel[i]) chl.push_back(i);
          k = 0;
          in_frame = 1;
        end
        if (in_frame) begin
          last_m = (k == chl.size() - 1);
          pend_w = {m_seq, 3'(chl[k]), last_m, smp_data};
          pend_v = 1;
          k++;
          idle = 0;
          if (last_m) begin
            in_frame = 0;
            m_seq = m_seq + 4'd1;
            e_done = 1;
          end
        end
      end else if (in_frame) begin
        idle++;
        if (idle == GAP_TO) begin
          in_frame = 0;
          idle = 0;
          ferr_set = 1;
        end
      end
      e_ov   = (e_ov && !err_clr) || drop_m;
      e_ferr = (e_ferr && !err_clr) || ferr_set;
    end
  end

  logic [23:0] got[$];
  int          done_cnt = 0;

  always @(negedge clk) begin
    check("out_valid",  32'(stream.out_valid), 32'(q.size() > 0));
    check("out_data",   32'(stream.out_data), (q.size() > 0) ? 32'(q[0]) : 32'd0);
    check("fifo_level", 32'(fifo_level), 32'(q.size()));
    check("frame_done", 32'(frame_done), 32'(e_done));
    check("overflow",   32'(overflow), 32'(e_ov));
    check("frame_err",  32'(frame_err), 32'(e_ferr));
    if (stream.out_valid && stream.out_ready) got.push_back(stream.out_data);
    if (frame_done) done_cnt++;
  end

  task automatic idle_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [DW-1:0] d);
    @(posedge clk);
    #1 smp_data = d;
    smp_vld = 1'b1;
    @(posedge clk);
    #1 smp_vld = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_cyc(2);
    rst_n = 1'b1;
    idle_cyc(1);
    got.delete();
    done_cnt = 0;
  endtask

  initial begin
    stream.out_ready = 1'b0;
    do_reset();
    check("rst_valid", 32'(stream.out_valid), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_ovf",   32'(overflow), 32'd0);
    check("rst_ferr",  32'(frame_err), 32'd0);

    // full mask, one frame
    stream.out_ready = 1'b1;
    channel = 8'hFF;
    for (int i = 0; i < 8; i++) pulse(16'h1000 + 16'(i));
    idle_cyc(4);
    check("t1_count", 32'(got.size()), 32'd8);
    check("t1_first", 32'(got[0]), 32'h001000);
    check("t1_last",  32'(got[7]), 32'h0F1007);
    check("t1_done",  32'(done_cnt), 32'd1);

    // sparse mask, sequence wrap
    do_reset();
    channel = 8'b1010_0100;
    for (int f = 0; f < 17; f++)
      for (int j = 0; j < 3; j++) pulse(16'h2000 + 16'(f * 3 + j));
    idle_cyc(4);
    check("t2_count",  32'(got.size()), 32'd51);
    check("t2_f0last", 32'(got[2]), 32'h0F2002);
    check("t2_f15",    32'(got[47]), 32'hFF202F);
    check("t2_wrap",   32'(got[48]), 32'h042030);

    // overflow with stalled consumer
    do_reset();
    stream.out_ready = 1'b0;
    channel = 8'hFF;
    for (int i = 0; i < 40; i++) pulse(16'h3000 + 16'(i));
    idle_cyc(3);
    check("t3_level", 32'(fifo_level), 32'd32);
    check("t3_ovf",   32'(overflow), 32'd1);
    stream.out_ready = 1'b1;
    idle_cyc(40);
    check("t3_drained", 32'(fifo_level), 32'd0);
    got.delete();
    for (int i = 0; i < 8; i++) pulse(16'h3100 + 16'(i));
    idle_cyc(4);
    check("t3_seq5_first", 32'(got[0]), 32'h503100);
    check("t3_seq5_last",  32'(got[7]), 32'h5F3107);
    err_clr = 1'b1;
    idle_cyc(1);
    err_clr = 1'b0;
    idle_cyc(1);
    check("t3_ovf_clr", 32'(overflow), 32'd0);

    // gap timeout boundary
    do_reset();
    channel = 8'hFF;
    for (int i = 0; i < 3; i++) pulse(16'h4000 + 16'(i));
    idle_cyc(63);
    check("t4_ferr_63", 32'(frame_err), 32'd0);
    idle_cyc(1);
    check("t4_ferr_64", 32'(frame_err), 32'd1);
    check("t4_nodone",  32'(done_cnt), 32'd0);
    pulse(16'h4100);
    idle_cyc(4);
    check("t4_restart", 32'(got[3]), 32'h004100);

    // mask change mid-frame is deferred
    do_reset();
    channel = 8'hFF;
    pulse(16'h5000);
    pulse(16'h5001);
    channel = 8'h0F;
    pulse(16'h5002);
    pulse(16'h5003);
    idle_cyc(70);
    check("t5_ferr", 32'(frame_err), 32'd1);
    for (int i = 0; i < 4; i++) pulse(16'h5100 + 16'(i));
    idle_cyc(4);
    check("t5_first", 32'(got[4]), 32'h005100);
    check("t5_last",  32'(got[7]), 32'h075103);
    check("t5_done",  32'(done_cnt), 32'd1);

    // reset mid-frame with buffered words
    do_reset();
    stream.out_ready = 1'b0;
    channel = 8'hFF;
    for (int i = 0; i < 4; i++) pulse(16'h6000 + 16'(i));
    idle_cyc(2);
    check("t6_valid_pre", 32'(stream.out_valid), 32'd1);
    rst_n = 1'b0;
    idle_cyc(1);
    check("t6_valid", 32'(stream.out_valid), 32'd0);
    check("t6_level", 32'(fifo_level), 32'd0);
    rst_n = 1'b1;
    got.delete();
    stream.out_ready = 1'b1;
    pulse(16'h6100);
    idle_cyc(4);
    check("t6_ch0", 32'(got[0]), 32'h006100);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
